// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Default payload widths at each stage boundary.
    localparam int IF_ID_W = 64;
    localparam int ID_EX_W = 72;
    localparam int EX_ME_W = 72;
    localparam int ME_WB_W = 40;

    function automatic logic [1:0] occ_of(input pipe_state_t st);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (st)
            ONE:     occ = OCC_ONE;
            FULL:    occ = OCC_FULL;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// stall, flush and a back-pressure cycle counter.
//
// state | meaning
// EMPTY | nothing held
// ONE   | main holds the only (oldest) payload
// FULL  | main holds oldest, skid holds the younger payload (SKID=1 only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 72,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cnt
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_valid;
    logic              room;
    logic              accept;
    logic              take;

    assign main_valid = (state_q != EMPTY);

    // With SKID=1 readiness comes from registered state only; SKID=0 trades
    // that for a combinational path from out_ready.
    generate
        if (SKID) begin : g_skid
            assign room = (state_q != FULL);
        end else begin : g_noskid
            assign room = ~main_valid | out_ready;
        end
    endgenerate

    assign in_ready  = rst & ~stall & ~flush & room;
    assign out_valid = main_valid & ~stall;
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bp_cnt (
        .clk (clk),
        .rst (rst),
        .inc (in_valid & ~in_ready),
        .clr (cnt_clr),
        .cnt (bp_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0/CNT_W=2 instance share stimulus,
// each checked every cycle against a small FIFO reference model.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       rdy0, rdy1, ov0, ov1;
    logic [7:0] od0, od1;
    logic [1:0] occ0, occ1;
    logic [15:0] bp0;
    logic [1:0]  bp1;

    logic        rdy [2];
    logic        ov  [2];
    logic [7:0]  od  [2];
    logic [1:0]  occ [2];
    logic [15:0] bpx [2];
    assign rdy[0] = rdy0;  assign rdy[1] = rdy1;
    assign ov[0]  = ov0;   assign ov[1]  = ov1;
    assign od[0]  = od0;   assign od[1]  = od1;
    assign occ[0] = occ0;  assign occ[1] = occ1;
    assign bpx[0] = bp0;   assign bpx[1] = {14'd0, bp1};

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: per instance a FIFO of depth 2, its length, the value
    // out_data should show, and the back-pressure count.
    logic [7:0]  mq   [2][2];
    int          mn   [2];
    logic [7:0]  mod  [2];
    logic [15:0] mbp  [2];
    logic [15:0] bpmax[2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .SKID(1'b1), .CNT_W(16)) u_dut_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .stall(stall),
        .flush(flush), .cnt_clr(cnt_clr), .occupancy(occ0), .bp_cnt(bp0)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(1'b0), .CNT_W(2)) u_dut_noskid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .stall(stall),
        .flush(flush), .cnt_clr(cnt_clr), .occupancy(occ1), .bp_cnt(bp1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mn[d]  = 0;
            mod[d] = 8'h00;
            mbp[d] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        out_ready = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_in_ready%0d", d), rdy[d], 0);
            chk($sformatf("rst_out_valid%0d", d), ov[d], 0);
            chk($sformatf("rst_out_data%0d", d), od[d], 0);
            chk($sformatf("rst_occ%0d", d), occ[d], 0);
            chk($sformatf("rst_bp%0d", d), bpx[d], 0);
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic st, input logic fl, input logic clr);
        logic erdy [2];
        logic acc  [2];
        logic tk   [2];
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy;
        stall = st; flush = fl; cnt_clr = clr;
        #1;
        for (int d = 0; d < 2; d++) begin
            erdy[d] = !st && !fl && ((d == 0) ? (mn[d] < 2) : (mn[d] == 0 || ordy));
            acc[d]  = iv && erdy[d];
            tk[d]   = (mn[d] > 0) && !st && ordy;
            chk($sformatf("in_ready%0d", d), rdy[d], erdy[d]);
            chk($sformatf("out_valid%0d", d), ov[d], (mn[d] > 0) && !st);
            chk($sformatf("out_data%0d", d), od[d], mod[d]);
            chk($sformatf("occupancy%0d", d), occ[d], mn[d]);
            chk($sformatf("bp_cnt%0d", d), bpx[d], mbp[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (fl) begin
                mn[d]  = 0;
                mod[d] = 8'h00;
            end else begin
                if (tk[d]) begin
                    mq[d][0] = mq[d][1];
                    mn[d]--;
                end
                if (acc[d]) begin
                    mq[d][mn[d]] = id;
                    mn[d]++;
                end
                if (mn[d] > 0) mod[d] = mq[d][0];
            end
            if (clr) mbp[d] = 16'h0000;
            else if (iv && !erdy[d] && mbp[d] != bpmax[d]) mbp[d] = mbp[d] + 16'd1;
        end
    endtask

    initial begin
        bpmax[0] = 16'hFFFF;
        bpmax[1] = 16'h0003;
        model_reset();
        do_reset();

        // streaming at full rate
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // back-pressure fills the skid buffer, then drains in order
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bp_full_occ", occ0, 2);
        chk("bp_full_cnt", bp0, 1);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // stall with 0x44 held
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 8'h45, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stall_occ", occ0, 1);
        chk("stall_data", od0, 8'h44);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // flush while full with 0x55 presented
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("flush_occ", occ0, 0);
        chk("flush_data", od0, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // 2-bit counter saturation and clear priority
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cnt_sat", bp1, 3);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("cnt_clr", bp1, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // randomized traffic with one reset mid-run
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 31) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
